vpi_param_gen: RTL and testbench

- Stimulus stage directly upstream of the VPI parameter-check module.
- Produces one parameter vector per accepted handshake: a[15:0], b[6:0] and c[31:0].
- After a start pulse it emits a programmable number of vectors, then pulses done.
- a comes from a 16-bit LFSR, b from a wrapping step counter, and c is the vector index.

---
 rtl/vpi_param_pkg.sv | 25 ++
 rtl/vpi_lfsr16.sv | 30 +++
 rtl/vpi_param_gen.sv | 122 ++++++++++++
 tb/tb_vpi_param_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vpi_param_pkg.sv
// Shared widths, FSM state encoding, LFSR taps and default seed for the VPI parameter generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vpi_param_pkg;

    localparam int A_W = 16;
    localparam int B_W = 7;
    localparam int C_W = 32;

    // Taps at bits 15, 13, 12 and 10 of the Fibonacci LFSR
    localparam logic [A_W-1:0] LFSR_TAPS    = 16'hB400;
    localparam logic [A_W-1:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Left-shift Fibonacci step: feedback is the parity of the tapped bits
    function automatic logic [A_W-1:0] lfsr_next(input logic [A_W-1:0] v);
        return {v[A_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/vpi_lfsr16.sv
// 16-bit Fibonacci LFSR register with seed load and advance; a zero seed is replaced by 1.
// Latency: new value visible one cycle after load/advance.
// Backpressure: holds its value whenever advance is low.
module vpi_lfsr16
    import vpi_param_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           advance,
    output logic [A_W-1:0] value
);

    // The all-zero state is a lock-up point for this LFSR, so never load it
    localparam logic [A_W-1:0] SEED_SAFE = (SEED == '0) ? 16'h0001 : SEED;

    // Load has priority over advance; otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= SEED_SAFE;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/vpi_param_gen.sv
// Emits num_vec (a, b, c) parameter vectors after a start pulse, then pulses done; optional chksum via VPI_PARAM_GEN_CHKSUM_EN.
// Latency: first vector valid the cycle after start; one vector per cycle while ready stays high.
// Backpressure: valid/ready; a/b/c held stable while valid && !ready, start ignored outside IDLE.
module vpi_param_gen
    import vpi_param_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = DEFAULT_SEED,
    parameter int          B_STEP    = 1,
    parameter int          MAX_VEC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [MAX_VEC_W-1:0] num_vec,
    input  logic                 ready,
    output logic                 valid,
    output logic [A_W-1:0]       a,
    output logic [B_W-1:0]       b,
    output logic [C_W-1:0]       c,
    output logic                 busy,
    output logic                 done
`ifdef VPI_PARAM_GEN_CHKSUM_EN
    ,
    output logic [31:0]          chksum
`endif
);

    localparam logic [B_W-1:0] B_INC = B_W'(B_STEP);

    state_t               state;
    logic [MAX_VEC_W-1:0] num_vec_q;
    logic                 start_acc;
    logic                 run_start;
    logic                 hs;
    logic                 last_vec;
    logic                 lfsr_adv;

    assign start_acc = (state == ST_IDLE) && start;
    assign run_start = start_acc && (num_vec != '0);
    // valid is only ever high in RUN, so a handshake implies RUN
    assign hs        = valid && ready;
    assign last_vec  = (c == (C_W'(num_vec_q) - 32'd1));
    assign lfsr_adv  = hs && !last_vec;

    vpi_lfsr16 #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (run_start),
        .advance (lfsr_adv),
        .value   (a)
    );

    // Run-control FSM with registered valid/busy/done and the b/c counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            b         <= '0;
            c         <= '0;
            num_vec_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (num_vec != '0) begin
                            num_vec_q <= num_vec;
                            b         <= '0;
                            c         <= '0;
                            valid     <= 1'b1;
                            state     <= ST_RUN;
                        end else begin
                            // Empty run: straight to the done pulse, no vector
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (hs) begin
                        if (last_vec) begin
                            valid <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            b <= b + B_INC;
                            c <= c + 32'd1;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef VPI_PARAM_GEN_CHKSUM_EN
    // Running XOR signature of every accepted vector; cleared by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chksum <= '0;
        end else if (start_acc) begin
            chksum <= '0;
        end else if (hs) begin
            chksum <= chksum ^ {a, 9'b0, b} ^ c;
        end
    end
`endif

endmodule

// File: tb/tb_vpi_param_gen.sv
// Scoreboard bench for vpi_param_gen: a reference model pushes expected vectors at start,
// a negedge monitor pops and compares them on every handshake and checks hold under stall.
// Directed runs cover basic, backpressure, zero-length, ignored start, b wrap and mid-run reset.
module tb_vpi_param_gen;

    typedef struct packed {
        logic [15:0] a;
        logic [6:0]  b;
        logic [31:0] c;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] num_vec;
    logic        ready;
    logic        valid;
    logic [15:0] a;
    logic [6:0]  b;
    logic [31:0] c;
    logic        busy;
    logic        done;
`ifdef VPI_PARAM_GEN_CHKSUM_EN
    logic [31:0] chksum;
`endif

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    logic valid_seen = 1'b0;
    logic prev_stall = 1'b0;
    logic [55:0] held = '0;
    vec_t sb[$];

    vpi_param_gen dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .num_vec (num_vec),
        .ready   (ready),
        .valid   (valid),
        .a       (a),
        .b       (b),
        .c       (c),
        .busy    (busy),
        .done    (done)
`ifdef VPI_PARAM_GEN_CHKSUM_EN
        ,
        .chksum  (chksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent reference LFSR step written from the tap list
    function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic push_run(input int n);
        logic [15:0] ma;
        ma = 16'hACE1;
        for (int i = 0; i < n; i++) begin
            vec_t e;
            e.a = ma;
            e.b = 7'(i % 128);
            e.c = 32'(i);
            sb.push_back(e);
            ma = ref_lfsr(ma);
        end
    endtask

    // One-cycle start pulse; expectations queued alongside
    task automatic kick(input int n);
        @(posedge clk); #1;
        start   = 1'b1;
        num_vec = 16'(n);
        push_run(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Cycles (sampled 1 time unit after each edge) until done is seen
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", {63'b0, done}, 64'd1);
    endtask

    // Monitor: scoreboard pop on handshake, hold check across stalled cycles
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {8'b0, valid, a, b, c}, {8'b0, held});
            if (valid && ready) begin
                chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    vec_t e;
                    e = sb.pop_front();
                    chk("vec_a", 64'(a), 64'(e.a));
                    chk("vec_b", 64'(b), 64'(e.b));
                    chk("vec_c", 64'(c), 64'(e.c));
                end
            end
            if (valid) valid_seen = 1'b1;
            if (done)  done_cnt++;
            prev_stall = valid && !ready;
            held       = {valid, a, b, c};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int d0;
        rst_n   = 1'b0;
        start   = 1'b0;
        num_vec = '0;
        ready   = 1'b1;
        #12;
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_abc",   64'({a, b, c}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic run, ready held high
        d0 = done_cnt;
        kick(3);
        chk("basic_first_valid", 64'(valid), 64'd1);
        chk("basic_busy", 64'(busy), 64'd1);
        wait_done(cyc);
        chk("basic_done_lat", 64'(cyc), 64'd3);
        chk("basic_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
        chk("basic_busy_drop", 64'(busy), 64'd0);
        chk("basic_done_pulse", 64'(done), 64'd0);
        chk("basic_done_once", 64'(done_cnt - d0), 64'd1);

        // Backpressure: four stalled cycles on the first vector
        ready = 1'b0;
        kick(2);
        repeat (4) begin @(posedge clk); #1; end
        chk("bp_valid", 64'(valid), 64'd1);
        chk("bp_first", 64'({a, b, c}), 64'({16'hACE1, 7'd0, 32'd0}));
        ready = 1'b1;
        wait_done(cyc);
        chk("bp_done_lat", 64'(cyc), 64'd2);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;

        // Zero-length run
        d0 = done_cnt;
        valid_seen = 1'b0;
        kick(0);
        wait_done(cyc);
        chk("zero_done_lat", 64'(cyc), 64'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk("zero_no_valid", 64'(valid_seen), 64'd0);
        chk("zero_done_once", 64'(done_cnt - d0), 64'd1);

        // Start re-pulsed mid-run is ignored
        kick(6);
        @(posedge clk); #1;
        start = 1'b1; num_vec = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc);
        chk("ign_done_lat", 64'(cyc), 64'd4);
        chk("ign_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;

        // b wrap across 128
        kick(130);
        wait_done(cyc);
        chk("wrap_done_lat", 64'(cyc), 64'd130);
        chk("wrap_last_b", 64'(b), 64'd1);
        chk("wrap_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;

        // Reset in the middle of a run
        d0 = done_cnt;
        kick(10);
        cyc = 0;
        while (c != 32'd5 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("mid_reach_c5", 64'(c), 64'd5);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_valid", 64'(valid), 64'd0);
        chk("mid_rst_abc", 64'({a, b, c}), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_no_done", 64'(done_cnt - d0), 64'd0);
        kick(3);
        chk("mid_restart", 64'({a, c}), 64'({16'hACE1, 32'd0}));
        wait_done(cyc);
        chk("mid_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;

`ifdef VPI_PARAM_GEN_CHKSUM_EN
        kick(1);
        wait_done(cyc);
        @(posedge clk); #1;
        chk("chksum_1", 64'(chksum), 64'h0000_0000_ACE1_0000);
        kick(2);
        wait_done(cyc);
        @(posedge clk); #1;
        chk("chksum_2", 64'(chksum), 64'h0000_0000_F522_0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
